// File: rtl/isram_arb.sv
// Single-port instruction SRAM arbiter: fetch owns the port by default, an LSU
// access steals one slot (ACC) and then hands the port back with a re-fetch (END).
`timescale 1ns/1ps
module isram_arb #(
    parameter int unsigned FET_GAP = 1
) (
    input  logic        clk,
    input  logic        cpurst,
    input  logic        fet_cs,
    input  logic [31:3] fet_adr,
    input  logic        lsu_req,
    input  logic [31:0] lsu_adr,
    input  logic        lsu_we,
    input  logic [3:0]  lsu_be,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lr_isram_cs,
    output logic        lr_isram_cs_endp,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [31:3] sram_adr,
    output logic [7:0]  sram_bwe,
    output logic [63:0] sram_wdata,
    input  logic [63:0] sram_rdata
);

    localparam logic [3:0] GAP_INIT = 4'(FET_GAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] gap_cnt;
    logic       lane_ff;
    logic       we_ff;
    logic       in_acc;
    logic       in_end;
    logic       unused_adr;

    function automatic logic [7:0] lane_bwe(input logic lane, input logic [3:0] be);
        return lane ? {be, 4'b0000} : {4'b0000, be};
    endfunction

    function automatic logic [31:0] lane_word(input logic lane, input logic [63:0] dw);
        return lane ? dw[63:32] : dw[31:0];
    endfunction

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state   <= S_IDLE;
            gap_cnt <= 4'd0;
            lane_ff <= 1'b0;
            we_ff   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu_req && gap_cnt == 4'd0)
                        state <= S_ACC;
                    if (gap_cnt != 4'd0)
                        gap_cnt <= gap_cnt - 4'd1;
                end
                S_ACC: begin
                    lane_ff <= lsu_adr[2];
                    we_ff   <= lsu_we;
                    state   <= S_END;
                end
                S_END: begin
                    // Reload the gap so fetch gets guaranteed slots before the next steal.
                    gap_cnt <= GAP_INIT;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_acc = (state == S_ACC);
    assign in_end = (state == S_END);

    assign lsu_gnt          = in_acc;
    assign lr_isram_cs      = in_acc | in_end;
    assign lr_isram_cs_endp = in_end;
    assign lsu_rvalid       = in_end & ~we_ff;
    assign lsu_rdata        = lane_word(lane_ff, sram_rdata);

    // Port mux: LSU only during ACC, fetch otherwise (including the END re-read).
    assign sram_cs    = in_acc | fet_cs;
    assign sram_adr   = in_acc ? lsu_adr[31:3] : fet_adr;
    assign sram_we    = in_acc & lsu_we;
    assign sram_bwe   = (in_acc && lsu_we) ? lane_bwe(lsu_adr[2], lsu_be) : 8'h00;
    assign sram_wdata = {lsu_wdata, lsu_wdata};

    assign unused_adr = ^lsu_adr[1:0];

endmodule

// File: doc/isram_arb.md
# isram_arb

Arbiter and sequencer for the single-port 64-bit instruction SRAM. Instruction fetch owns the port by default. A load/store request that targets ISRAM address space steals one access slot. The block then drives `lr_isram_cs` so fetch holds its PC, and pulses `lr_isram_cs_endp` so fetch re-issues its read. It sits between the PC-generation logic, the LSU and the ISRAM macro.

## Interface
Parameters:
- `FET_GAP`, default 1: minimum number of fetch-only IDLE cycles after each LSU access before the next LSU request is honoured. Range 0–15.

Ports:
- `clk` input 1: the single clock.
- `cpurst` input 1: synchronous, active-high reset.
- `fet_cs` input 1: fetch read strobe.
- `fet_adr` input [31:3]: fetch doubleword address.
- `lsu_req` input 1: LSU access request; held until granted.
- `lsu_adr` input [31:0]: LSU byte address; bits [1:0] ignored.
- `lsu_we` input 1: 1 = write, 0 = read.
- `lsu_be` input [3:0]: write byte enables within the word.
- `lsu_wdata` input [31:0]: write data.
- `lsu_gnt` output 1: request accepted this cycle.
- `lsu_rvalid` output 1: read data valid.
- `lsu_rdata` output [31:0]: read word.
- `lr_isram_cs` output 1: LSU owns or has just owned the port; fetch must stall.
- `lr_isram_cs_endp` output 1: last stall cycle; fetch must assert its strobe.
- `sram_cs` output 1: SRAM chip select.
- `sram_we` output 1: SRAM write enable.
- `sram_adr` output [31:3]: SRAM address.
- `sram_bwe` output [7:0]: SRAM byte write enables.
- `sram_wdata` output [63:0]: SRAM write data.
- `sram_rdata` input [63:0]: SRAM read data, valid one cycle after `sram_cs`.

## Operation
State machine with three states: IDLE, ACC and END.

IDLE:
- SRAM port muxed to fetch: `sram_cs=fet_cs`, `sram_adr=fet_adr`, `sram_we=0`.
- If `lsu_req=1` and `gap_cnt==0`, go to ACC.
- If `gap_cnt!=0`, decrement `gap_cnt`.

ACC:
- SRAM driven from LSU: `sram_cs=1`, `sram_adr=lsu_adr[31:3]`, `sram_we=lsu_we`.
- Byte enables: `sram_bwe = lsu_adr[2] ? {lsu_be,4'b0} : {4'b0,lsu_be}`, gated by `lsu_we`.
- `sram_wdata = {lsu_wdata,lsu_wdata}`.
- `lsu_gnt=1`, `lr_isram_cs=1`.
- `fet_cs` is ignored; fetch is stalled.
- Latch `lsu_adr[2]` into `lane_ff` and `lsu_we` into `we_ff`.
- Go to END unconditionally.

END:
- SRAM port returned to fetch, as in IDLE.
- `lr_isram_cs=1`, `lr_isram_cs_endp=1`.
- `lsu_rvalid = !we_ff`.
- `lsu_rdata = lane_ff ? sram_rdata[63:32] : sram_rdata[31:0]`.
- Load `gap_cnt=FET_GAP` and go to IDLE.

Other rules:
- `lsu_rdata` is don't-care whenever `lsu_rvalid=0`; the bench checks it only with `lsu_rvalid`.
- LSU handshake: `lsu_adr`, `lsu_we`, `lsu_be` and `lsu_wdata` stay stable from `lsu_req` rise until `lsu_gnt`. The requester may change them or drop `lsu_req` in the cycle after `lsu_gnt`.
- A write completes in ACC and produces no `lsu_rvalid`.
- A request dropped before grant is never granted.
- A request held through END is treated as a new request, subject to the gap.
- Fetch fairness: with `FET_GAP=N`, at least N IDLE cycles separate END from the next ACC.

## Timing
- Reset (`cpurst=1` at a clock edge): state=IDLE, `gap_cnt=0`, `lane_ff=0`, `we_ff=0`.
- Outputs during and after reset, until the first LSU request: `lsu_gnt`, `lsu_rvalid`, `lr_isram_cs`, `lr_isram_cs_endp` and `sram_we` are 0. `sram_cs`, `sram_adr` and `sram_bwe` follow fetch, with `sram_bwe=0`.
- Reset mid-transaction in ACC or END: the transaction is dropped, no `lsu_rvalid` is issued, and the next state is IDLE.
- LSU access with `lsu_req` high in IDLE at cycle T and `gap_cnt==0`:
  - T+1: ACC, `lsu_gnt=1`.
  - T+2: END, `lsu_rvalid` and `lr_isram_cs_endp` high.
  - T+3: IDLE.
- Load latency from request to `lsu_rvalid` is 2 cycles.
- Fetch stall: `lr_isram_cs` is high for exactly 2 cycles (ACC and END). The fetch re-read in END returns data in the following IDLE cycle.
- Back-to-back LSU grants are spaced 3+`FET_GAP` cycles apart.
- If `FET_GAP=0`, a request held through END is granted with the next ACC at T+4.
- Combinational paths:
  - `sram_*` outputs depend on state and the current-cycle fetch/LSU inputs.
  - `lsu_rdata` depends on `sram_rdata` and `lane_ff`.
  - `lsu_gnt`, `lr_isram_cs` and `lr_isram_cs_endp` depend on state only.
- `lsu_req` arriving in the same cycle as `fet_cs`: fetch is served that cycle, and the LSU takes the next cycle.

## Test plan
- **Reset:** hold `cpurst` 3 cycles with `fet_cs=1`, `fet_adr=29'h100` -> `sram_cs=1`, `sram_adr=29'h100`, `sram_we=0`; `lsu_gnt`, `lsu_rvalid`, `lr_isram_cs`, `lr_isram_cs_endp` all 0.
- **Single read:** `lsu_req=1`, `lsu_we=0`, `lsu_adr=32'h0000_0A0C` at T; `sram_rdata=64'h1111_2222_3333_4444` at T+2 -> `lsu_gnt`@T+1 with `sram_adr=29'h141`; `lsu_rvalid`@T+2 with `lsu_rdata=32'h1111_2222`; `lr_isram_cs` high only at T+1 and T+2; `lr_isram_cs_endp` only at T+2.
- **Write:** `lsu_we=1`, `lsu_adr=32'h10`, `lsu_be=4'b0011`, `lsu_wdata=32'hDEADBEEF` -> in ACC: `sram_we=1`, `sram_bwe=8'h03`, `sram_wdata=64'hDEADBEEF_DEADBEEF`, `sram_adr=29'h2`; no `lsu_rvalid`.
- **Back-to-back requests with `FET_GAP=1`:** `lsu_req` held high continuously -> grants at T+1 and T+5; at T+3 and T+4 the SRAM follows fetch.
- **Back-to-back requests with `FET_GAP=0`:** `lsu_req` held high continuously -> grants at T+1 and T+4.
- **Reset mid-operation:** assert `cpurst` in ACC -> next cycle IDLE, `lsu_rvalid=0`, `lr_isram_cs=0`; a following request is served normally.
